// File: rtl/usb_tx_line.sv
// USB full-speed transmit line stage: bit stuffing, NRZI encoding onto dp/dm,
// EOP generation (SE0 then J) and return to idle, with upstream back-pressure.
module usb_tx_line #(
    parameter int unsigned STUFF_LEN    = 6,
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic clk,
    input  logic rst_L,
    input  logic start,
    input  logic stream_bit,
    input  logic stream_valid,
    input  logic stream_last,
    output logic halt_stream,
    output logic dp,
    output logic dm,
    output logic oe,
    output logic line_done,
    output logic underrun
);

    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
    localparam int unsigned SE0_W  = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
    localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(STUFF_LEN - 1);
    localparam logic [SE0_W-1:0]  SE0_LAST  = SE0_W'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_STUFF,
        S_EOP_SE0,
        S_EOP_J
    } state_e;

    state_e              state_q, state_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [SE0_W-1:0]    se0_q, se0_d;
    logic                last_q, last_d;
    logic                dp_q, dp_d;
    logic                dm_q, dm_d;
    logic                oe_q, oe_d;
    logic                halt_q, halt_d;
    logic                done_q, done_d;
    logic                underrun_q, underrun_d;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= S_IDLE;
            ones_q     <= '0;
            se0_q      <= '0;
            last_q     <= 1'b0;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            oe_q       <= 1'b0;
            halt_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            se0_q      <= se0_d;
            last_q     <= last_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            oe_q       <= oe_d;
            halt_q     <= halt_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    // Line outputs show the symbol decided on the previous edge (one cycle of latency).
    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        se0_d      = se0_q;
        last_d     = last_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        oe_d       = oe_q;
        halt_d     = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;

        case (state_q)
            S_IDLE: begin
                dp_d   = 1'b1;
                dm_d   = 1'b0;
                oe_d   = 1'b0;
                // oe is still high only on the first idle cycle after the EOP J
                done_d = oe_q;
                if (start) begin
                    state_d    = S_ACTIVE;
                    underrun_d = 1'b0;
                    ones_d     = '0;
                end
            end
            S_ACTIVE: begin
                if (stream_valid && !halt_q) begin
                    oe_d = 1'b1;
                    if (!stream_bit) begin
                        dp_d   = ~dp_q;
                        dm_d   = dp_q;
                        ones_d = '0;
                    end else begin
                        ones_d = ones_q + ONES_W'(1);
                    end
                    if (stream_bit && (ones_q == ONES_LAST)) begin
                        halt_d  = 1'b1;
                        ones_d  = '0;
                        last_d  = stream_last;
                        state_d = S_STUFF;
                    end else if (stream_last) begin
                        se0_d   = '0;
                        state_d = S_EOP_SE0;
                    end
                end else if (!stream_valid) begin
                    underrun_d = 1'b1;
                end
            end
            S_STUFF: begin
                dp_d    = ~dp_q;
                dm_d    = dp_q;
                se0_d   = '0;
                state_d = last_q ? S_EOP_SE0 : S_ACTIVE;
            end
            S_EOP_SE0: begin
                dp_d = 1'b0;
                dm_d = 1'b0;
                oe_d = 1'b1;
                if (se0_q == SE0_LAST) begin
                    state_d = S_EOP_J;
                end else begin
                    se0_d = se0_q + SE0_W'(1);
                end
            end
            S_EOP_J: begin
                dp_d    = 1'b1;
                dm_d    = 1'b0;
                oe_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign halt_stream = halt_q;
    assign dp          = dp_q;
    assign dm          = dm_q;
    assign oe          = oe_q;
    assign line_done   = done_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_usb_tx_line.sv
// Bench for usb_tx_line: hand-computed packet table, random packets against a
// list-based stuffing/NRZI model, and multi-cycle corner sequences.
module tb_usb_tx_line;

    localparam int unsigned STUFF_N = 6;
    localparam int unsigned SE0_N   = 2;

    typedef struct packed {
        logic dp;
        logic dm;
        logic oe;
        logic halt;
        logic done;
    } obs_t;

    typedef struct {
        int          len;
        logic [15:0] bits;
        int          nsym;
        logic [15:0] dp_seq;
        int          halts;
    } vec_t;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    logic start = 1'b0;
    logic stream_bit = 1'b0;
    logic stream_valid = 1'b0;
    logic stream_last = 1'b0;
    logic halt_stream, dp, dm, oe, line_done, underrun;

    int n_tests = 0;
    int n_fail  = 0;

    usb_tx_line #(.STUFF_LEN(STUFF_N), .EOP_SE0_BITS(SE0_N)) dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .start        (start),
        .stream_bit   (stream_bit),
        .stream_valid (stream_valid),
        .stream_last  (stream_last),
        .halt_stream  (halt_stream),
        .dp           (dp),
        .dm           (dm),
        .oe           (oe),
        .line_done    (line_done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
        end
    endtask

    function automatic obs_t sample();
        return {dp, dm, oe, halt_stream, line_done};
    endfunction

    // Expected per-cycle observation list from the start edge to line_done.
    task automatic model(input bit bits[$], output obs_t exp[$]);
        bit   sb[$];
        bit   is_stuff[$];
        int   ones = 0;
        logic lvl = 1'b1;
        exp.delete();
        foreach (bits[i]) begin
            sb.push_back(bits[i]);
            is_stuff.push_back(1'b0);
            ones = bits[i] ? ones + 1 : 0;
            if (ones == int'(STUFF_N)) begin
                sb.push_back(1'b0);
                is_stuff.push_back(1'b1);
                ones = 0;
            end
        end
        exp.push_back(5'b10000);
        foreach (sb[j]) begin
            if (!sb[j]) lvl = ~lvl;
            exp.push_back({lvl, ~lvl, 1'b1,
                           (j + 1 < sb.size()) ? logic'(is_stuff[j + 1]) : 1'b0, 1'b0});
        end
        for (int k = 0; k < int'(SE0_N); k++) exp.push_back(5'b00100);
        exp.push_back(5'b10100);
        exp.push_back(5'b10001);
    endtask

    // Upstream driver honouring halt_stream; samples every cycle at the falling edge.
    task automatic send(input bit bits[$], input int gap_at, input int gap_len,
                        input int poke_at, output obs_t got[$]);
        int   p = 0;
        int   gap = gap_len;
        int   cyc = 0;
        bit   hprev;
        bit   vdrv = 1'b0;
        obs_t o = '0;
        int   n = bits.size();
        got.delete();
        @(negedge clk);
        start = 1'b1;
        stream_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        o = sample();
        got.push_back(o);
        hprev = o.halt;
        while (cyc < 300) begin
            if (p == gap_at && gap > 0) begin
                stream_valid = 1'b0;
                gap--;
                vdrv = 1'b0;
            end else if (p < n) begin
                stream_bit   = bits[p];
                stream_last  = (p == n - 1);
                stream_valid = 1'b1;
                vdrv = 1'b1;
            end else begin
                stream_valid = 1'b0;
                stream_last  = 1'b0;
                vdrv = 1'b0;
            end
            @(negedge clk);
            o = sample();
            got.push_back(o);
            cyc++;
            if (vdrv && !hprev) p++;
            hprev = o.halt;
            start = (got.size() == poke_at);
            if (o.done) break;
        end
        start = 1'b0;
        stream_valid = 1'b0;
        stream_last = 1'b0;
        check("done_within_bound", 32'(o.done), 32'd1);
    endtask

    task automatic cmp_seq(input string name, input obs_t got[$], input obs_t exp[$]);
        check($sformatf("%s_len", name), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_cyc%0d", name, i), 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        vec_t tbl[6];
        obs_t got[$];
        obs_t exp[$];
        bit   bits[$];
        logic [15:0] dps;
        int   halts;
        int   bad_dm;
        int   dones;
        int   n;

        tbl[0] = '{len: 8,  bits: 16'h0080, nsym: 8,  dp_seq: 16'h002A, halts: 0};
        tbl[1] = '{len: 15, bits: 16'h7F80, nsym: 16, dp_seq: 16'hE02A, halts: 1};
        tbl[2] = '{len: 6,  bits: 16'h003F, nsym: 7,  dp_seq: 16'h003F, halts: 1};
        tbl[3] = '{len: 4,  bits: 16'h0000, nsym: 4,  dp_seq: 16'h000A, halts: 0};
        tbl[4] = '{len: 12, bits: 16'h0FFF, nsym: 14, dp_seq: 16'h203F, halts: 2};
        tbl[5] = '{len: 7,  bits: 16'h005F, nsym: 7,  dp_seq: 16'h001F, halts: 0};

        #12;
        check("reset_state", 32'({dp, dm, oe, halt_stream, line_done, underrun}), 32'b100000);
        @(negedge clk);
        rst_L = 1'b1;

        foreach (tbl[t]) begin
            bits.delete();
            for (int i = 0; i < tbl[t].len; i++) begin
                dps = tbl[t].bits;
                bits.push_back(dps[i]);
            end
            send(bits, -1, 0, -1, got);
            n = tbl[t].nsym;
            check($sformatf("tbl%0d_len", t), 32'(got.size()), 32'(n + 5));
            check($sformatf("tbl%0d_pre", t), 32'(got[0]), 32'b10000);
            dps = '0;
            halts = 0;
            bad_dm = 0;
            for (int i = 0; i < got.size(); i++) if (got[i].halt) halts++;
            for (int i = 0; i < n && i + 1 < got.size(); i++) begin
                dps[i] = got[i + 1].dp;
                if (got[i + 1].dm !== ~got[i + 1].dp || got[i + 1].oe !== 1'b1) bad_dm++;
            end
            check($sformatf("tbl%0d_dp_seq", t), 32'(dps), 32'(tbl[t].dp_seq));
            check($sformatf("tbl%0d_dm_oe", t), 32'(bad_dm), 32'd0);
            check($sformatf("tbl%0d_halts", t), 32'(halts), 32'(tbl[t].halts));
            if (got.size() >= n + 5)
                check($sformatf("tbl%0d_eop", t),
                      32'({got[n + 1], got[n + 2], got[n + 3], got[n + 4]}),
                      32'({5'b00100, 5'b00100, 5'b10100, 5'b10001}));
        end

        for (int r = 0; r < 10; r++) begin
            bits.delete();
            n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) bits.push_back($urandom_range(0, 3) != 0);
            model(bits, exp);
            send(bits, -1, 0, -1, got);
            cmp_seq($sformatf("rand%0d", r), got, exp);
        end

        // valid dropped for two cycles: line held, underrun sticky until next start
        bits = '{0, 0, 0, 0, 0, 0, 0, 1};
        send(bits, 3, 2, -1, got);
        check("gap_len", 32'(got.size()), 32'd15);
        if (got.size() >= 15) begin
            check("gap_hold0", 32'(got[4]), 32'b01100);
            check("gap_hold1", 32'(got[5]), 32'b01100);
            check("gap_resume", 32'(got[6]), 32'b10100);
            check("gap_eop", 32'({got[11], got[12], got[13], got[14]}),
                  32'({5'b00100, 5'b00100, 5'b10100, 5'b10001}));
        end
        @(negedge clk);
        check("underrun_sticky", 32'(underrun), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("underrun_cleared", 32'(underrun), 32'd0);
        rst_L = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;

        // start pulsed while in EOP_SE0 must be ignored
        bits = '{0, 0, 0, 0};
        model(bits, exp);
        send(bits, -1, 0, 5, got);
        cmp_seq("start_in_eop", got, exp);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (line_done || oe) dones++;
        end
        check("no_second_packet", 32'(dones), 32'd0);

        // asynchronous reset while halt_stream is high
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stream_bit = 1'b1;
        stream_last = 1'b0;
        stream_valid = 1'b1;
        halts = 0;
        for (int i = 0; i < 20 && halts == 0; i++) begin
            @(negedge clk);
            if (halt_stream) halts = 1;
        end
        check("halt_before_reset", 32'(halts), 32'd1);
        #2 rst_L = 1'b0;
        #1 check("async_reset", 32'({dp, dm, oe, halt_stream, line_done, underrun}), 32'b100000);
        stream_valid = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        bits = '{0, 0, 0, 0, 0, 0, 0, 1};
        model(bits, exp);
        send(bits, -1, 0, -1, got);
        cmp_seq("after_reset", got, exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
